// File: rtl/t07_fpu_div.sv
// Restoring shift-subtract divider for unsigned 9.23 fixed point: one quotient bit per cycle, 56-edge latency.
// Optional round-to-nearest (ties up) when T07_FPU_DIV_ROUND_EN is defined; truncation otherwise.
module t07_fpu_div (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        signA,
  input  logic        signB,
  output logic [31:0] result,
  output logic        sign,
  output logic        overflow,
  output logic        div_by_zero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] op_b;
  logic        op_sign;
  logic [32:0] rem;
  logic [54:0] quot;

  logic [33:0] trial;
  logic        trial_ge;
  logic [32:0] rem_nxt;
  logic [54:0] quot_nxt;
  logic [54:0] quot_fin;
  logic        q_ovf;
  logic        last_iter;

  assign last_iter = (cnt == 6'd54);

  // quot starts as the dividend and shifts left; its MSB feeds the remainder
  // while the new quotient bit enters at the LSB.
  assign trial    = {rem, quot[54]};
  assign trial_ge = (trial >= {2'b00, op_b});
  assign rem_nxt  = trial_ge ? (trial[32:0] - {1'b0, op_b}) : trial[32:0];
  assign quot_nxt = {quot[53:0], trial_ge};

`ifdef T07_FPU_DIV_ROUND_EN
  logic round_up;
  assign round_up = ({rem_nxt, 1'b0} >= {2'b00, op_b});
  assign quot_fin = quot_nxt + {54'd0, round_up};
`else
  assign quot_fin = quot_nxt;
`endif

  assign q_ovf = |quot_fin[54:32];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (inB == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt         <= 6'd0;
      op_b        <= 32'd0;
      op_sign     <= 1'b0;
      rem         <= 33'd0;
      quot        <= 55'd0;
      result      <= 32'd0;
      sign        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_b    <= inB;
            op_sign <= signA ^ signB;
            rem     <= 33'd0;
            quot    <= {inA, 23'd0};
            cnt     <= 6'd0;
            if (inB == 32'd0) begin
              result      <= 32'd0;
              sign        <= signA ^ signB;
              overflow    <= 1'b1;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 6'd1;
          if (last_iter) begin
            sign        <= op_sign;
            div_by_zero <= 1'b0;
            overflow    <= q_ovf;
            result      <= q_ovf ? 32'd0 : quot_fin[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t07_fpu_div.sv
// Bench for t07_fpu_div: vector table plus reset/scramble sequences, scoreboard queue of expected results.
module tb_t07_fpu_div;

`ifdef T07_FPU_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        signA;
  logic        signB;
  logic [31:0] result;
  logic        sign;
  logic        overflow;
  logic        div_by_zero;
  logic        busy;
  logic        done;

  t07_fpu_div dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .inA         (inA),
    .inB         (inB),
    .signA       (signA),
    .signB       (signB),
    .result      (result),
    .sign        (sign),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [31:0] res;
    logic        sgn;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sa,
                              input logic sb, input logic [31:0] res_trunc,
                              input logic [31:0] res_round, input logic ovf);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.sa  = sa;
    v.sb  = sb;
    v.res = ROUND ? res_round : res_trunc;
    v.sgn = sa ^ sb;
    v.ovf = ovf;
    v.dbz = (b == 32'd0);
    v.lat = (b == 32'd0) ? 1 : 56;
    v.bsy = (b == 32'd0) ? 0 : 55;
    return v;
  endfunction

  // Arithmetic reference: 64-bit integer division of the scaled dividend.
  function automatic vec_t mdl(input logic [31:0] a, input logic [31:0] b, input logic sa,
                               input logic sb);
    logic [63:0] dvd;
    logic [63:0] q;
    logic [63:0] r;
    logic        ov;
    dvd = {9'd0, a, 23'd0};
    if (b == 32'd0) return mk(a, b, sa, sb, 32'd0, 32'd0, 1'b1);
    q = dvd / {32'd0, b};
    r = dvd % {32'd0, b};
    if (ROUND && ((r << 1) >= {32'd0, b})) q = q + 64'd1;
    ov = (q[63:32] != 32'd0);
    return mk(a, b, sa, sb, ov ? 32'd0 : q[31:0], ov ? 32'd0 : q[31:0], ov);
  endfunction

  task automatic run_op(input vec_t v, input bit scramble, input string tag);
    logic [34:0] pre;
    bit          held;
    bit          seen;
    int          lat;
    int          bcnt;
    vec_t        e;
    @(negedge clk);
    inA   = v.a;
    inB   = v.b;
    signA = v.sa;
    signB = v.sb;
    start = 1'b1;
    sb_q.push_back(v);
    pre  = {result, sign, overflow, div_by_zero};
    held = 1'b1;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    @(posedge clk);
    #1;
    if (!scramble) start = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        if (busy) bcnt++;
        if ({result, sign, overflow, div_by_zero} !== pre) held = 1'b0;
        if (scramble) begin
          start = ~start;
          inA   = $urandom;
          inB   = $urandom;
          signA = 1'($urandom);
          signB = 1'($urandom);
        end
      end
    end
    e = sb_q.pop_front();
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_busy_cycles"}, bcnt, e.bsy);
      chk({tag, "_held_during_run"}, {31'd0, held}, 32'd1);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_sign"}, {31'd0, sign}, {31'd0, e.sgn});
      chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
      chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
      chk({tag, "_result_holds"}, result, e.res);
    end
  endtask

  initial begin
    vec_t v;
    bit   stale;
    nrst  = 1'b0;
    start = 1'b0;
    inA   = 32'd0;
    inB   = 32'd0;
    signA = 1'b0;
    signB = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {24'd0, result[7:0] | result[15:8] | result[23:16] | result[31:24]}, 32'd0);
    chk("reset_flags", {26'd0, sign, overflow, div_by_zero, busy, done, 1'b0}, 32'd0);
    nrst = 1'b1;

    tbl.push_back(mk(32'h03000000, 32'h01000000, 1'b0, 1'b1, 32'h01800000, 32'h01800000, 1'b0));
    tbl.push_back(mk(32'h00800000, 32'h01800000, 1'b0, 1'b0, 32'h002AAAAA, 32'h002AAAAB, 1'b0));
    tbl.push_back(mk(32'h7F800000, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1));
    tbl.push_back(mk(32'h00000000, 32'h00400000, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0));
    tbl.push_back(mk(32'h00800000, 32'h00800000, 1'b1, 1'b1, 32'h00800000, 32'h00800000, 1'b0));
    tbl.push_back(mk(32'hFFFFFFFF, 32'h00800000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    tbl.push_back(mk(32'hFFFFFFFF, 32'h007FFFFF, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1));
    tbl.push_back(mk(32'h00000001, 32'h01000000, 1'b0, 1'b0, 32'h00000000, 32'h00000001, 1'b0));
    tbl.push_back(mk(32'h00000001, 32'h01000001, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0));
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      tbl.push_back(mdl(ra, rb, 1'($urandom), 1'($urandom)));
    end
    tbl.push_back(mk(32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1));

    foreach (tbl[i]) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Mid-run asynchronous reset after a zero-divide left sign/overflow/div_by_zero set.
    @(negedge clk);
    inA   = 32'h03000000;
    inB   = 32'h01000000;
    signA = 1'b1;
    signB = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'd0, sign, overflow, div_by_zero, busy, done}, 32'd0);
    @(negedge clk);
    nrst  = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) stale = 1'b1;
    end
    chk("rst_no_stale_activity", {31'd0, stale}, 32'd0);
    v = mk(32'h00800000, 32'h00800000, 1'b0, 1'b0, 32'h00800000, 32'h00800000, 1'b0);
    run_op(v, 1'b0, "post_reset");

    v = mk(32'h03000000, 32'h01000000, 1'b1, 1'b0, 32'h01800000, 32'h01800000, 1'b0);
    run_op(v, 1'b1, "scramble");

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/t07_fpu_div.md
T07_FPU_DIV -- requirements
Module: t07_fpu_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port nrst, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have ports inA and inB, input, 32 bits each: dividend and divisor magnitudes, unsigned fixed point, 9 integer bits and 23 fraction bits (1.0 = 0x00800000).
REQ-005 SHALL have ports signA and signB, input, 1 bit each: operand signs.
REQ-006 SHALL have port result, output, 32 bits: quotient magnitude in the same 9.23 format.
REQ-007 SHALL have port sign, output, 1 bit: quotient sign.
REQ-008 SHALL have port overflow, output, 1 bit: the quotient does not fit in 32 bits, or the divisor is zero.
REQ-009 SHALL have port div_by_zero, output, 1 bit: the divisor was zero.
REQ-010 SHALL have port busy, output, 1 bit: high while iterating.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch inA, inB and signA^signB on that edge, then:
- inB != 0: go to RUN.
- inB == 0: go to DONE.
REQ-014 SHALL ignore start in RUN and DONE; operands latched earlier SHALL be unaffected by input changes.
REQ-015 SHALL compute floor(({inA, 23'b0}) / inB) using a restoring shift-subtract algorithm.
- Dividend width 55 bits; remainder width 33 bits.
- One quotient bit per cycle, MSB first.
REQ-016 SHALL stay in RUN for exactly 55 cycles, counted by a 6-bit counter that runs 0..54, then go to DONE.
REQ-017 busy SHALL be 1 exactly in RUN.
REQ-018 done SHALL be 1 exactly in DONE, which SHALL last one cycle and then return to IDLE.
REQ-019 For a nonzero divisor, done SHALL assert on the 56th rising edge after the start-sampling edge.
REQ-020 For a zero divisor, done SHALL assert on the first edge after the start-sampling edge.
REQ-021 On entry to DONE with a nonzero divisor:
- If quotient bits [54:32] are nonzero: overflow=1 and result=0.
- Otherwise: result = quotient[31:0] and overflow=0.
REQ-022 On entry to DONE with a zero divisor: div_by_zero=1, overflow=1, result=0.
REQ-023 sign SHALL equal the latched signA^signB, including for zero and overflow results.
REQ-024 result, sign, overflow and div_by_zero SHALL be registered.
- They SHALL update only on entry to DONE.
- They SHALL hold until the next DONE entry.
- They SHALL NOT change during RUN.
REQ-025 A dividend of 0 with a nonzero divisor SHALL take the full 55 cycles and produce result=0, overflow=0.

Reset
REQ-026 On nrst=0 the block SHALL asynchronously enter IDLE and clear every register to 0, regardless of the current state, including mid-RUN.
- Outputs cleared: result, sign, overflow, div_by_zero, busy, done.
- Internal state cleared: counter, remainder, quotient.
REQ-027 After reset is released, the first start SHALL be accepted normally; no partial result from the interrupted operation SHALL appear.

Configuration
REQ-028 With macro T07_FPU_DIV_ROUND_EN defined, the block SHALL round to nearest (ties up).
- When 2*remainder >= divisor, it SHALL add 1 to the 55-bit quotient before the overflow check of REQ-021.
- A carry into bit 32 SHALL therefore set overflow.
REQ-029 With T07_FPU_DIV_ROUND_EN undefined, the quotient SHALL be truncated with no rounding logic present; latency SHALL be identical in both builds.

Verification
REQ-030 inA=0x03000000 (6.0), inB=0x01000000 (2.0), signA=0, signB=1, start pulse -> busy for 55 cycles, then done pulse, result=0x01800000, sign=1, overflow=0, div_by_zero=0.
REQ-031 inA=0x00800000 (1.0), inB=0x01800000 (3.0) -> result=0x002AAAAA without T07_FPU_DIV_ROUND_EN, and result=0x002AAAAB with it.
REQ-032 inA=0x7F800000, inB=0x00000001 -> on done: overflow=1, result=0x00000000, div_by_zero=0.
REQ-033 inB=0x00000000, any inA -> done on the cycle after start, busy never 1, div_by_zero=1, overflow=1, result=0.
REQ-034 start a 6.0/2.0 division, pulse nrst low at RUN cycle 20 -> all outputs 0 and FSM in IDLE immediately; a new 1.0/1.0 request then yields result=0x00800000 at the 56th edge with no stale values.
REQ-035 During RUN, toggle start and change inA/inB every cycle -> no restart, latency stays 56 edges, and result matches the originally latched operands.
